// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter: fetch (i_) and data (d_) share one bus, one grant at a time.
// Define AVALON_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise data wins every tie.
module avalon_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [DATA_W-1:0]   i_writedata,
  input  logic [DATA_W/8-1:0] i_byteenable,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t state_r;
  logic   last_gnt_r;
  logic   i_req_s;
  logic   d_req_s;
  logic   tie_to_d_s;

  assign i_req_s    = i_read | i_write;
  assign d_req_s    = d_read | d_write;
  assign grant      = state_r;
  assign i_readdata = readdata;
  assign d_readdata = readdata;

  // Tie-break selection for simultaneous requests seen in IDLE.
  always_comb begin
    tie_to_d_s = 1'b1;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    tie_to_d_s = ~last_gnt_r;
`else
    // last_gnt is still tracked but never steers a fixed-priority tie.
    tie_to_d_s = last_gnt_r | 1'b1;
`endif
  end

  // Bus mux: forward the granted master straight through; idle drives zeros and stalls both.
  always_comb begin
    address       = {ADDR_W{1'b0}};
    read          = 1'b0;
    write         = 1'b0;
    writedata     = {DATA_W{1'b0}};
    byteenable    = {(DATA_W/8){1'b0}};
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state_r)
      GNT_I: begin
        address       = i_address;
        read          = i_read & ~i_write;
        write         = i_write;
        writedata     = i_writedata;
        byteenable    = i_byteenable;
        i_waitrequest = waitrequest;
      end
      GNT_D: begin
        address       = d_address;
        read          = d_read & ~d_write;
        write         = d_write;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
      end
      default: begin
        address       = {ADDR_W{1'b0}};
        read          = 1'b0;
        write         = 1'b0;
        writedata     = {DATA_W{1'b0}};
        byteenable    = {(DATA_W/8){1'b0}};
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
      end
    endcase
  end

  // Grant FSM and last-completed-grant tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_s && d_req_s) begin
            state_r <= tie_to_d_s ? GNT_D : GNT_I;
          end else if (i_req_s) begin
            state_r <= GNT_I;
          end else if (d_req_s) begin
            state_r <= GNT_D;
          end else begin
            state_r <= IDLE;
          end
        end
        GNT_I: begin
          if (!i_req_s) begin
            state_r <= IDLE;
          end else if (!waitrequest) begin
            // The completing master's strobe is never reused to regrant.
            last_gnt_r <= 1'b0;
            state_r    <= d_req_s ? GNT_D : IDLE;
          end else begin
            state_r <= GNT_I;
          end
        end
        GNT_D: begin
          if (!d_req_s) begin
            state_r <= IDLE;
          end else if (!waitrequest) begin
            last_gnt_r <= 1'b1;
            state_r    <= i_req_s ? GNT_I : IDLE;
          end else begin
            state_r <= GNT_D;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter; tie expectations follow AVALON_ARB_ROUND_ROBIN_EN.
module tb_avalon_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address, d_address, address;
  logic        i_read, i_write, d_read, d_write, read, write;
  logic [31:0] i_writedata, d_writedata, writedata;
  logic [3:0]  i_byteenable, d_byteenable, byteenable;
  logic        i_waitrequest, d_waitrequest, waitrequest;
  logic [31:0] i_readdata, d_readdata, readdata;
  logic [1:0]  grant;
  logic [1:0]  first_g;
  logic [1:0]  second_g;

  int n_tests = 0;
  int n_fail  = 0;

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_write(i_write),
    .i_writedata(i_writedata), .i_byteenable(i_byteenable),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    i_address = 32'h0; i_read = 1'b0; i_write = 1'b0; i_writedata = 32'h0; i_byteenable = 4'h0;
    d_address = 32'h0; d_read = 1'b0; d_write = 1'b0; d_writedata = 32'h0; d_byteenable = 4'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_read", read, 1'b0);
    chk("rst_i_wait", i_waitrequest, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_grant", grant, 2'b00);
    chk("rel_addr", address, 32'h0);
    chk("rel_d_wait", d_waitrequest, 1'b1);

    // Fetch-only read, zero wait
    i_address = 32'h0000_0010; i_read = 1'b1; readdata = 32'hDEAD_BEEF;
    #1;
    chk("f_arb_read", read, 1'b0);
    chk("f_arb_wait", i_waitrequest, 1'b1);
    step();
    chk("f_grant", grant, 2'b01);
    chk("f_read", read, 1'b1);
    chk("f_addr", address, 32'h0000_0010);
    chk("f_i_wait", i_waitrequest, 1'b0);
    chk("f_rdata", i_readdata, 32'hDEAD_BEEF);
    chk("f_d_rdata", d_readdata, 32'hDEAD_BEEF);
    chk("f_d_wait", d_waitrequest, 1'b1);
    step();
    i_read = 1'b0;
    #1;
    chk("f_done_grant", grant, 2'b00);
    chk("f_done_read", read, 1'b0);

    // First tie after reset: data, then fetch with no idle gap
    i_address = 32'h20; i_read = 1'b1; d_address = 32'h30; d_read = 1'b1;
    step();
    chk("t1_first", grant, 2'b10);
    chk("t1_addr_d", address, 32'h30);
    chk("t1_i_wait", i_waitrequest, 1'b1);
    step();
    d_read = 1'b0;
    #1;
    chk("t1_second", grant, 2'b01);
    chk("t1_addr_i", address, 32'h20);
    step();
    i_read = 1'b0;
    #1;
    chk("t1_idle", grant, 2'b00);

    // Data-only transfer so the last completed grant is data
    d_address = 32'h40; d_read = 1'b1;
    step();
    chk("d_only", grant, 2'b10);
    step();
    d_read = 1'b0;
    #1;
    chk("d_only_idle", grant, 2'b00);

    // Repeat tie: round-robin picks fetch, fixed priority picks data
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    first_g = 2'b01;
`else
    first_g = 2'b10;
`endif
    second_g = ~first_g;
    i_read = 1'b1; d_read = 1'b1;
    step();
    chk("t2_first", grant, first_g);
    step();
    if (first_g == 2'b01) i_read = 1'b0;
    else d_read = 1'b0;
    #1;
    chk("t2_second", grant, second_g);
    step();
    i_read = 1'b0; d_read = 1'b0;
    #1;
    chk("t2_idle", grant, 2'b00);

    // Data write held through 3 wait states
    d_address = 32'h100; d_write = 1'b1; d_writedata = 32'hCAFE_F00D; d_byteenable = 4'b0011;
    waitrequest = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) waitrequest = 1'b0;
      #1;
      chk("w_grant", grant, 2'b10);
      chk("w_write", write, 1'b1);
      chk("w_addr", address, 32'h100);
      chk("w_data", writedata, 32'hCAFE_F00D);
      chk("w_be", byteenable, 4'b0011);
      chk("w_d_wait", d_waitrequest, (k < 3) ? 1'b1 : 1'b0);
      chk("w_i_wait", i_waitrequest, 1'b1);
      step();
    end
    d_write = 1'b0;
    #1;
    chk("w_idle", grant, 2'b00);
    chk("w_idle_write", write, 1'b0);

    // Dropped fetch request falls back to IDLE
    i_address = 32'h50; i_read = 1'b1; waitrequest = 1'b1;
    step();
    chk("drop_grant", grant, 2'b01);
    chk("drop_i_wait", i_waitrequest, 1'b1);
    i_read = 1'b0;
    step();
    chk("drop_idle", grant, 2'b00);

    // Read and write together: write wins, then reset mid-transfer
    d_address = 32'h60; d_read = 1'b1; d_write = 1'b1;
    step();
    chk("rw_write", write, 1'b1);
    chk("rw_read", read, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_grant", grant, 2'b00);
    chk("abort_write", write, 1'b0);
    chk("abort_read", read, 1'b0);
    d_read = 1'b0; d_write = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("abort_i_wait", i_waitrequest, 1'b1);
    chk("abort_d_wait", d_waitrequest, 1'b1);
    step();
    chk("abort_idle", grant, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
